// File: rtl/dm_access_seq.sv
// Load/store sequencer between the MEM stage and a word-wide synchronous RAM.
// Word-crossing accesses become two beats; loads are merged and sign/zero extended.
module dm_access_seq #(
  parameter bit ALLOW_MISALIGN = 1'b1
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_type,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_req,
  input  logic        mem_gnt,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_we,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [2:0] {
    S_IDLE, S_BEAT0, S_WAIT0, S_BEAT1, S_WAIT1, S_RESP
  } state_e;

  state_e      state_q, state_d;
  logic        we_q, we_d;
  logic        split_q, split_d;
  logic        err_q, err_d;
  logic [2:0]  type_q, type_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rd0_q, rd0_d;
  logic [31:0] rd1_q, rd1_d;

  function automatic logic [3:0] size_mask(input logic [2:0] t);
    case (t)
      3'b000:         return 4'b1111;
      3'b001, 3'b010: return 4'b0011;
      default:        return 4'b0001;
    endcase
  endfunction

  function automatic logic crosses(input logic [1:0] o, input logic [2:0] t);
    logic [2:0] n;
    case (t)
      3'b000:         n = 3'd4;
      3'b001, 3'b010: n = 3'd2;
      default:        n = 3'd1;
    endcase
    return ({1'b0, o} + n) > 3'd4;
  endfunction

  function automatic logic [31:0] ld_extend(input logic [2:0] t, input logic [31:0] d);
    case (t)
      3'b001:  return {{16{d[15]}}, d[15:0]};
      3'b010:  return {16'h0000, d[15:0]};
      3'b011:  return {{24{d[7]}}, d[7:0]};
      3'b100:  return {24'h000000, d[7:0]};
      default: return d;
    endcase
  endfunction

  logic        split_in;
  logic [1:0]  off;
  logic [7:0]  lanes;
  logic [63:0] wd_sh;
  logic [31:0] rd_asm;
  logic [31:0] beat0_addr;
  logic [31:0] beat1_addr;

  assign split_in   = crosses(req_addr[1:0], req_type);
  assign off        = addr_q[1:0];
  // Lane masks and shifted data span both beats: low half is beat 0, high half beat 1.
  assign lanes      = {4'b0000, size_mask(type_q)} << off;
  assign wd_sh      = {32'h0, wdata_q} << {off, 3'b000};
  assign rd_asm     = 32'({rd1_q, rd0_q} >> {off, 3'b000});
  assign beat0_addr = {addr_q[31:2], 2'b00};
  assign beat1_addr = beat0_addr + 32'd4;

  always_comb begin
    state_d    = state_q;
    we_d       = we_q;
    split_d    = split_q;
    err_d      = err_q;
    type_d     = type_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rd0_d      = rd0_q;
    rd1_d      = rd1_q;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    resp_err   = 1'b0;
    resp_rdata = 32'h0;
    mem_req    = 1'b0;
    mem_addr   = 32'h0;
    mem_we     = 4'b0000;
    mem_wdata  = 32'h0;
    case (state_q)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          we_d    = req_we;
          type_d  = req_type;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          split_d = split_in;
          err_d   = (req_type > 3'd4) || (split_in && !ALLOW_MISALIGN);
          state_d = err_d ? S_RESP : S_BEAT0;
        end
      end
      S_BEAT0: begin
        mem_req  = 1'b1;
        mem_addr = beat0_addr;
        if (we_q) begin
          mem_we    = lanes[3:0];
          mem_wdata = wd_sh[31:0];
        end
        if (mem_gnt) state_d = !we_q ? S_WAIT0 : (split_q ? S_BEAT1 : S_RESP);
      end
      S_WAIT0: begin
        rd0_d   = mem_rdata;
        state_d = split_q ? S_BEAT1 : S_RESP;
      end
      S_BEAT1: begin
        mem_req  = 1'b1;
        mem_addr = beat1_addr;
        if (we_q) begin
          mem_we    = lanes[7:4];
          mem_wdata = wd_sh[63:32];
        end
        if (mem_gnt) state_d = we_q ? S_RESP : S_WAIT1;
      end
      S_WAIT1: begin
        rd1_d   = mem_rdata;
        state_d = S_RESP;
      end
      S_RESP: begin
        resp_valid = 1'b1;
        resp_err   = err_q;
        if (!err_q && !we_q) resp_rdata = ld_extend(type_q, rd_asm);
        if (resp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      we_q    <= 1'b0;
      split_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      split_q <= split_d;
      err_q   <= err_d;
    end
  end

  // Datapath holds are never observed outside their owning states, so no reset.
  always_ff @(posedge clk) begin
    type_q  <= type_d;
    addr_q  <= addr_d;
    wdata_q <= wdata_d;
    rd0_q   <= rd0_d;
    rd1_q   <= rd1_d;
  end

endmodule

// File: tb/tb_dm_access_seq.sv
// Bench for dm_access_seq: RAM responder with grant stalls, byte-level reference
// memory, directed scenarios, then randomized loads/stores.
module tb_dm_access_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstn = 1'b1;
  logic        req_valid = 1'b0, req_we = 1'b0;
  logic [2:0]  req_type = 3'b000;
  logic [31:0] req_addr = 32'h0, req_wdata = 32'h0;
  logic        req_ready, resp_valid, resp_err;
  logic        resp_ready = 1'b1;
  logic [31:0] resp_rdata;
  logic        mem_req;
  logic        mem_gnt = 1'b0;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_we;
  logic [31:0] mem_rdata = 32'h0;

  logic        req_valid2 = 1'b0, req_we2 = 1'b0;
  logic [2:0]  req_type2 = 3'b000;
  logic [31:0] req_addr2 = 32'h0, req_wdata2 = 32'h0;
  logic        req_ready2, resp_valid2, resp_err2;
  logic        resp_ready2 = 1'b1;
  logic [31:0] resp_rdata2;
  logic        mem_req2;
  logic        mem_gnt2 = 1'b1;
  logic [31:0] mem_addr2, mem_wdata2;
  logic [3:0]  mem_we2;
  logic [31:0] mem_rdata2 = 32'h0;

  dm_access_seq #(.ALLOW_MISALIGN(1'b1)) u_dut (
    .clk(clk), .rstn(rstn),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_type(req_type),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_req(mem_req), .mem_gnt(mem_gnt), .mem_addr(mem_addr), .mem_we(mem_we),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  dm_access_seq #(.ALLOW_MISALIGN(1'b0)) u_dut_nm (
    .clk(clk), .rstn(rstn),
    .req_valid(req_valid2), .req_ready(req_ready2), .req_we(req_we2), .req_type(req_type2),
    .req_addr(req_addr2), .req_wdata(req_wdata2),
    .resp_valid(resp_valid2), .resp_ready(resp_ready2), .resp_rdata(resp_rdata2), .resp_err(resp_err2),
    .mem_req(mem_req2), .mem_gnt(mem_gnt2), .mem_addr(mem_addr2), .mem_we(mem_we2),
    .mem_wdata(mem_wdata2), .mem_rdata(mem_rdata2)
  );

  int n_checks = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  // ---------------- RAM responder ----------------
  logic [31:0] ram [logic [31:0]];
  int          stall_cfg = 0;
  int          stall_cnt = 0;
  bit          in_beat = 0, pend_load = 0, stable_bad = 0, nm_seen = 0;
  logic [31:0] pend_addr, cap_addr, cap_wdata;
  logic [3:0]  cap_we;
  logic [31:0] b_addr[$];
  logic [3:0]  b_we[$];
  logic [31:0] b_wdata[$];

  function automatic logic [31:0] init_word(input logic [31:0] w);
    return (w * 32'h9E3779B1) ^ 32'h5A5A5A5A;
  endfunction

  function automatic logic [31:0] ram_rd(input logic [31:0] w);
    if (ram.exists(w)) return ram[w];
    return init_word(w);
  endfunction

  always @(negedge clk) begin
    logic [31:0] w;
    if (pend_load) begin
      mem_rdata = ram_rd(pend_addr);
      pend_load = 0;
    end else begin
      mem_rdata = $urandom;
    end
    if (!mem_req) begin
      in_beat = 0;
      mem_gnt = 1'b0;
    end else begin
      if (!in_beat) begin
        in_beat   = 1;
        stall_cnt = stall_cfg;
        cap_addr  = mem_addr;
        cap_we    = mem_we;
        cap_wdata = mem_wdata;
      end else if (mem_addr !== cap_addr || mem_we !== cap_we || mem_wdata !== cap_wdata) begin
        stable_bad = 1;
      end
      if (stall_cnt > 0) begin
        mem_gnt = 1'b0;
        stall_cnt--;
      end else begin
        mem_gnt = 1'b1;
        in_beat = 0;
        b_addr.push_back(mem_addr);
        b_we.push_back(mem_we);
        b_wdata.push_back(mem_wdata);
        if (mem_we != 4'b0000) begin
          w = ram_rd(mem_addr);
          for (int i = 0; i < 4; i++) if (mem_we[i]) w[8*i +: 8] = mem_wdata[8*i +: 8];
          ram[mem_addr] = w;
        end else begin
          pend_load = 1;
          pend_addr = mem_addr;
        end
      end
    end
  end

  always @(posedge clk) if (mem_req2) nm_seen = 1;

  // ---------------- Byte-level reference memory ----------------
  logic [7:0] mem_b [logic [31:0]];

  function automatic logic [7:0] ref_byte(input logic [31:0] a);
    logic [31:0] w;
    if (mem_b.exists(a)) return mem_b[a];
    w = init_word({a[31:2], 2'b00});
    return w[8*a[1:0] +: 8];
  endfunction

  function automatic int nbytes(input logic [2:0] t);
    case (t)
      3'd0:       return 4;
      3'd1, 3'd2: return 2;
      default:    return 1;
    endcase
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] t, input logic [31:0] a);
    logic [31:0] v = 32'h0;
    for (int i = 0; i < nbytes(t); i++) v[8*i +: 8] = ref_byte(a + 32'(i));
    if (t == 3'd1 && v[15]) v = v | 32'hFFFF0000;
    if (t == 3'd3 && v[7])  v = v | 32'hFFFFFF00;
    return v;
  endfunction

  function automatic logic [31:0] lanemask(input logic [3:0] m);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = {8{m[i]}};
    return r;
  endfunction

  task automatic preload(input logic [31:0] a, input logic [31:0] w);
    ram[a] = w;
    for (int i = 0; i < 4; i++) mem_b[a + 32'(i)] = w[8*i +: 8];
  endtask

  // ---------------- Transaction drivers ----------------
  logic [31:0] last_rd;
  int          last_lat;

  task automatic do_req(input logic we, input logic [2:0] ty, input logic [31:0] a,
                        input logic [31:0] wd, input int hold, input logic [31:0] exp_rd,
                        output int lat, output logic [31:0] rd, output logic er);
    int n;
    b_addr.delete(); b_we.delete(); b_wdata.delete();
    req_valid = 1'b1; req_we = we; req_type = ty; req_addr = a; req_wdata = wd;
    resp_ready = (hold == 0);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
      req_valid = 1'b0;
    end while (!resp_valid && n < 40);
    lat = n; rd = resp_rdata; er = resp_err;
    for (int i = 0; i < hold; i++) begin
      chk("hold_resp_valid", resp_valid, 1);
      chk("hold_resp_rdata", resp_rdata, exp_rd);
      chk("hold_req_ready", req_ready, 0);
      @(posedge clk); #1;
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    chk("post_handshake_valid_ready", {resp_valid, req_ready}, 2'b01);
  endtask

  task automatic run_txn(input logic we, input logic [2:0] ty, input logic [31:0] a,
                         input logic [31:0] wd, input int stall, input int hold);
    int n, nb, exp_lat, lat, k;
    logic split, er_exp, er;
    logic [31:0] exp_rd, rd, ba;
    logic [3:0]  ewe [2];
    logic [31:0] ewd [2];
    n      = nbytes(ty);
    er_exp = (ty > 3'd4);
    split  = (int'(a[1:0]) + n) > 4;
    nb     = er_exp ? 0 : (split ? 2 : 1);
    exp_lat = er_exp ? 1 : ((we ? (split ? 3 : 2) : (split ? 5 : 3)) + stall * nb);
    exp_rd = (er_exp || we) ? 32'h0 : ref_load(ty, a);
    ewe[0] = 4'b0; ewe[1] = 4'b0; ewd[0] = 32'h0; ewd[1] = 32'h0;
    if (we && !er_exp) begin
      for (int i = 0; i < n; i++) begin
        ba = a + 32'(i);
        k  = (ba[31:2] == a[31:2]) ? 0 : 1;
        ewe[k][ba[1:0]] = 1'b1;
        ewd[k][8*ba[1:0] +: 8] = wd[8*i +: 8];
      end
    end
    stall_cfg = stall;
    do_req(we, ty, a, wd, hold, exp_rd, lat, rd, er);
    last_rd = rd; last_lat = lat;
    chk("resp_rdata", rd, exp_rd);
    chk("resp_err", er, er_exp);
    chk("latency", lat, exp_lat);
    chk("beat_count", b_addr.size(), nb);
    for (int j = 0; j < b_addr.size() && j < 2; j++) begin
      chk("beat_addr", b_addr[j], {a[31:2], 2'b00} + 32'(4*j));
      chk("beat_we", b_we[j], ewe[j]);
      if (we) chk("beat_wdata_lanes", b_wdata[j] & lanemask(ewe[j]), ewd[j]);
    end
    if (we && !er_exp) for (int i = 0; i < n; i++) mem_b[a + 32'(i)] = wd[8*i +: 8];
    stall_cfg = 0;
  endtask

  task automatic do_req_nm(input logic we, input logic [2:0] ty, input logic [31:0] a, input logic exp_err);
    int n;
    req_valid2 = 1'b1; req_we2 = we; req_type2 = ty; req_addr2 = a; req_wdata2 = 32'hDEADBEEF;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
      req_valid2 = 1'b0;
    end while (!resp_valid2 && n < 20);
    chk("nm_latency", n, 1);
    chk("nm_resp_err", resp_err2, exp_err);
    chk("nm_resp_rdata", resp_rdata2, 32'h0);
    @(posedge clk); #1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bit resp_seen;
    bit req_seen;
    int st, hd;
    logic [2:0] ty;

    // ---- reset ----
    #1 rstn = 1'b0;
    #2;
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_resp_err", resp_err, 0);
    chk("rst_resp_rdata", resp_rdata, 32'h0);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_we", mem_we, 4'h0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    @(posedge clk); @(negedge clk);
    rstn = 1'b1;
    @(posedge clk); #1;
    chk("rst_req_ready", req_ready, 1);

    preload(32'h100, 32'h84332211);
    preload(32'h104, 32'h88776655);

    // ---- directed loads ----
    run_txn(1'b0, 3'd0, 32'h100, 32'h0, 0, 0);
    chk("lw_100_data", last_rd, 32'h84332211);
    chk("lw_100_lat", last_lat, 3);
    chk("lw_100_we", b_we[0], 4'h0);
    run_txn(1'b0, 3'd3, 32'h103, 32'h0, 0, 0);
    chk("lb_103", last_rd, 32'hFFFFFF84);
    run_txn(1'b0, 3'd4, 32'h103, 32'h0, 0, 0);
    chk("lbu_103", last_rd, 32'h00000084);
    run_txn(1'b0, 3'd1, 32'h103, 32'h0, 0, 0);
    chk("lh_103", last_rd, 32'h00005584);
    chk("lh_103_b0", b_addr[0], 32'h100);
    chk("lh_103_b1", b_addr[1], 32'h104);
    run_txn(1'b0, 3'd0, 32'h102, 32'h0, 0, 0);
    chk("lw_102", last_rd, 32'h66558433);
    chk("lw_102_lat", last_lat, 5);

    // ---- directed stores ----
    run_txn(1'b1, 3'd0, 32'h101, 32'hAABBCCDD, 0, 0);
    chk("sw_101_b0_addr", b_addr[0], 32'h100);
    chk("sw_101_b0_we", b_we[0], 4'b1110);
    chk("sw_101_b0_wd", b_wdata[0], 32'hBBCCDD00);
    chk("sw_101_b1_addr", b_addr[1], 32'h104);
    chk("sw_101_b1_we", b_we[1], 4'b0001);
    chk("sw_101_b1_wd", b_wdata[1], 32'h000000AA);
    chk("sw_101_lat", last_lat, 3);
    stable_bad = 0;
    run_txn(1'b1, 3'd1, 32'h102, 32'h00001234, 3, 0);
    chk("sh_102_beats", b_addr.size(), 1);
    chk("sh_102_we", b_we[0], 4'b1100);
    chk("sh_102_wd", b_wdata[0], 32'h12340000);
    chk("sh_102_lat", last_lat, 5);
    chk("sh_102_stable", stable_bad, 0);

    // ---- illegal type and backpressure ----
    run_txn(1'b0, 3'd6, 32'h100, 32'h0, 0, 0);
    run_txn(1'b0, 3'd0, 32'h100, 32'h0, 0, 4);
    chk("bp_lw_100", last_rd, 32'h1234DD11);

    // ---- reset during WAIT0 of a split load ----
    req_valid = 1'b1; req_we = 1'b0; req_type = 3'd1; req_addr = 32'h103;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("rstw_beat0_req", mem_req, 1);
    @(posedge clk); #1;
    rstn = 1'b0;
    #1;
    chk("rstw_mem_req", mem_req, 0);
    chk("rstw_resp_valid", resp_valid, 0);
    @(posedge clk); #1;
    rstn = 1'b1;
    resp_seen = 0; req_seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (resp_valid) resp_seen = 1;
      if (mem_req) req_seen = 1;
    end
    chk("rstw_no_resp", resp_seen, 0);
    chk("rstw_no_memreq", req_seen, 0);
    chk("rstw_req_ready", req_ready, 1);

    // ---- reset during a stalled BEAT0 ----
    stall_cfg = 5;
    req_valid = 1'b1; req_we = 1'b1; req_type = 3'd0; req_addr = 32'h108; req_wdata = 32'h55AA55AA;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    chk("rsts_mem_req_before", mem_req, 1);
    rstn = 1'b0;
    #1;
    chk("rsts_mem_req", mem_req, 0);
    chk("rsts_mem_we", mem_we, 4'h0);
    @(posedge clk); #1;
    rstn = 1'b1;
    stall_cfg = 0;
    resp_seen = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (resp_valid) resp_seen = 1;
    end
    chk("rsts_no_resp", resp_seen, 0);

    // ---- misalignment rejected ----
    do_req_nm(1'b0, 3'd0, 32'h101, 1'b1);
    do_req_nm(1'b0, 3'd6, 32'h100, 1'b1);
    do_req_nm(1'b1, 3'd1, 32'h103, 1'b1);
    chk("nm_no_memreq", nm_seen, 0);

    // ---- address wrap ----
    run_txn(1'b1, 3'd0, 32'hFFFFFFFE, 32'hCAFEF00D, 0, 0);
    chk("wrap_b1_addr", b_addr[1], 32'h00000000);
    run_txn(1'b0, 3'd0, 32'hFFFFFFFD, 32'h0, 1, 0);
    run_txn(1'b0, 3'd1, 32'hFFFFFFFF, 32'h0, 0, 0);

    // ---- randomized ----
    for (int t = 0; t < 80; t++) begin
      ty = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
      st = $urandom_range(0, 2);
      hd = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
      run_txn(1'($urandom_range(0, 1)), ty, 32'h100 + 32'($urandom_range(0, 31)), $urandom, st, hd);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
